// File: rtl/rv_muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// operation and state encodings plus small decode helpers.
package rv_muldiv_pkg;

  // Operation encoding: equals funct3 of OPC_OP with funct7 = 0000001
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Decoder mapping from funct3 (M-extension row of OPC_OP)
  function automatic md_op_t md_decode(input logic [2:0] funct3);
    return md_op_t'(funct3);
  endfunction

  function automatic logic md_is_div(input md_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(input md_op_t op);
    return op inside {MD_REM, MD_REMU};
  endfunction

  // rs1 is interpreted as two's complement
  function automatic logic md_rs1_signed(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 is interpreted as two's complement
  function automatic logic md_rs2_signed(input md_op_t op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/rv_muldiv_unit.sv
// Iterative multiply/divide unit, one result bit per cycle.
// Shift-add multiply and restoring divide share one 2*XLEN shift register
// and one XLEN+1 adder/subtractor; divide-by-zero and signed overflow
// complete in a single cycle.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   op, rs1, rs2        operation and operands, sampled on handshake
//   flush               synchronous kill of the in-flight operation
//   out_valid/out_ready result handshake
//   result              registered result, held under backpressure
//   busy                unit is not IDLE
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  md_op_t          op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned AW = 2 * XLEN;
  localparam int unsigned SW = XLEN + 1;
  localparam int unsigned CW = $clog2(XLEN + 1);

  md_state_t       state,     state_nxt;
  logic [AW-1:0]   acc,       acc_nxt;
  logic [XLEN-1:0] opb,       opb_nxt;
  md_op_t          op_q,      op_nxt;
  logic            neg_q,     neg_nxt;
  logic [CW-1:0]   cnt,       cnt_nxt;
  logic [XLEN-1:0] result_nxt;
  logic            out_valid_nxt;

  // Operand preparation at the input handshake
  logic            rs1_sgn, rs2_sgn;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            neg_init;

  always_comb begin
    rs1_sgn     = rs1[XLEN-1] & md_rs1_signed(op);
    rs2_sgn     = rs2[XLEN-1] & md_rs2_signed(op);
    rs1_mag     = rs1_sgn ? -rs1 : rs1;
    rs2_mag     = rs2_sgn ? -rs2 : rs2;
    div_zero    = md_is_div(op) && (rs2 == '0);
    div_ovf     = (op inside {MD_DIV, MD_REM}) &&
                  (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)     special_res = md_is_rem(op) ? rs1 : '1;
    else if (div_ovf) special_res = md_is_rem(op) ? '0  : rs1;
    // Remainder follows the dividend; everything else follows sign XOR
    neg_init    = (op == MD_REM) ? rs1_sgn : (rs1_sgn ^ rs2_sgn);
  end

  // One shift-add or restoring-divide step on the shared shift register.
  // Multiply: acc = {partial_hi, multiplier}, opb = multiplicand.
  // Divide:   acc = {remainder, dividend/quotient}, opb = divisor.
  logic            sub;
  logic [SW-1:0]   add_a, add_b, add_sum;
  logic [AW-1:0]   step;

  always_comb begin
    sub     = md_is_div(op_q);
    add_a   = sub ? {acc[AW-1:XLEN], acc[XLEN-1]} : {1'b0, acc[AW-1:XLEN]};
    add_b   = {1'b0, opb} ^ {SW{sub}};
    add_sum = add_a + add_b + SW'(sub);
    if (sub) begin
      // Borrow (top bit set) means the trial subtraction failed: restore
      step = {(add_sum[XLEN] ? add_a[XLEN-1:0] : add_sum[XLEN-1:0]),
              acc[XLEN-2:0], ~add_sum[XLEN]};
    end else if (acc[0]) begin
      step = {add_sum, acc[XLEN-1:1]};
    end else begin
      step = {1'b0, acc[AW-1:1]};
    end
  end

  // Sign correction and result selection on the final iteration
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, final_res;

  always_comb begin
    prod_fix = neg_q ? -step : step;
    quo_fix  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_fix  = neg_q ? -step[AW-1:XLEN] : step[AW-1:XLEN];
    case (op_q)
      MD_MUL:                      final_res = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[AW-1:XLEN];
      MD_DIV, MD_DIVU:             final_res = quo_fix;
      default:                     final_res = rem_fix;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    opb_nxt       = opb;
    op_nxt        = op_q;
    neg_nxt       = neg_q;
    cnt_nxt       = cnt;
    result_nxt    = result;
    out_valid_nxt = out_valid;
    case (state)
      MD_IDLE: begin
        if (in_valid) begin
          if (special) begin
            result_nxt    = special_res;
            out_valid_nxt = 1'b1;
            state_nxt     = MD_DONE;
          end else begin
            op_nxt    = op;
            neg_nxt   = neg_init;
            cnt_nxt   = CW'(XLEN);
            state_nxt = MD_CALC;
            if (md_is_div(op)) begin
              acc_nxt = {{XLEN{1'b0}}, rs1_mag};
              opb_nxt = rs2_mag;
            end else begin
              acc_nxt = {{XLEN{1'b0}}, rs2_mag};
              opb_nxt = rs1_mag;
            end
          end
        end
      end
      MD_CALC: begin
        acc_nxt = step;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_nxt    = final_res;
          out_valid_nxt = 1'b1;
          state_nxt     = MD_DONE;
        end
      end
      MD_DONE: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = MD_IDLE;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        state_nxt     = MD_IDLE;
      end
    endcase
    // Flush overrides everything, including a same-cycle request
    if (flush) begin
      state_nxt     = MD_IDLE;
      out_valid_nxt = 1'b0;
      result_nxt    = result;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      acc       <= '0;
      opb       <= '0;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      opb       <= opb_nxt;
      op_q      <= op_nxt;
      neg_q     <= neg_nxt;
      cnt       <= cnt_nxt;
      result    <= result_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  assign in_ready = (state == MD_IDLE);
  assign busy     = (state != MD_IDLE);

endmodule

// File: doc/rv_muldiv_unit.md
# rv_muldiv_unit

Iterative RV32M/RV64M multiply/divide unit: the multi-cycle successor to the single-cycle ALU op set, adding MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU at parametrised XLEN. It sits beside the ALU in the execute stage behind a valid/ready handshake. It computes one result bit per cycle with shift-add multiply and restoring divide, and resolves RISC-V divide special cases early.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8 (32 and 64 used)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; high exactly when state is IDLE
- op  in  md_op_t (3)  operation, sampled on input handshake
- rs1  in  XLEN  operand A / dividend, sampled on input handshake
- rs2  in  XLEN  operand B / divisor, sampled on input handshake
- flush  in  1  synchronous kill of any in-flight operation
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result; stable while out_valid && !out_ready
- busy  out  1  state != IDLE

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- States: IDLE, CALC, DONE.
- IDLE → CALC on in_valid && in_ready, normal case. Latches magnitudes, sign flags and op; counter = XLEN.
- IDLE → DONE directly on a special divide case:
  - Divisor 0, DIV/DIVU: quotient = all ones.
  - Divisor 0, REM/REMU: result = rs1.
  - DIV with rs1 = most negative and rs2 = −1: result = rs1.
  - REM with rs1 = most negative and rs2 = −1: result = 0.
- CALC: one iteration per cycle; counter decrements. On the cycle counter reaches 1:
  - Sign correction is applied and result is registered.
  - State goes to DONE.
- Multiply:
  - Unsigned shift-add over a 2·XLEN accumulator.
  - MUL returns low XLEN bits; MULH, MULHSU and MULHU return high XLEN bits.
  - Operand signedness: MULH signed × signed; MULHSU rs1 signed, rs2 unsigned; MULHU unsigned.
  - Negative operands are converted to magnitudes. The 2·XLEN product is negated when the operand signs differ.
- Divide:
  - Restoring divide on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
  - DIVU and REMU use no sign handling.
- DONE: out_valid = 1. On out_ready → IDLE. The result is held indefinitely under backpressure.
- flush:
  - Highest priority. Next edge: state = IDLE, out_valid = 0, result unchanged.
  - A flush in the same cycle as an input handshake discards that request.
- in_ready is low in CALC and DONE. There is no overlap; a new op is accepted only after the output handshake.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, busy 0, counter 0. in_ready reads 1 during and after reset.
- Normal latency: input handshake at edge N gives out_valid high from after edge N+XLEN (XLEN cycles in CALC).
- Special-case latency: out_valid high from after edge N+1.
- Throughput with out_ready held high:
  - Normal ops: one op per XLEN+2 cycles (handshake, XLEN CALC cycles, DONE).
  - Special cases: one op per 2 cycles.
- out_valid and result are registered; there is no combinational path from in_* to out_*.
- in_ready is combinational from state only.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values. The pending result is lost.

## Structure
- The shared definitions package gains md_op_t, a 3-bit enum:
  - MD_MUL = 0, MD_MULH = 1, MD_MULHSU = 2, MD_MULHU = 3
  - MD_DIV = 4, MD_DIVU = 5, MD_REM = 6, MD_REMU = 7
- The package also gains a 2-bit state enum md_state_t.
- Decoder mapping: funct3 from OPC_OP with funct7 = 0000001 maps 1:1 onto md_op_t.
- Single module, no sub-module. Multiply and divide share one 2·XLEN shift register and one XLEN+1 adder/subtractor.
- Counter width is $clog2(XLEN+1).

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), XLEN = 32 → 0xFFFFFFEB after exactly 32 CALC cycles. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH same operands → 0x00000000.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, each with out_valid one cycle after the handshake. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM same → 0.
- Backpressure: out_ready low for 5 cycles after out_valid. result, out_valid and in_ready=0 are held. Releasing out_ready gives in_ready=1 on the next cycle.
- Flush:
  - flush at CALC cycle 10 → IDLE next cycle, no out_valid. A following MUL 3 × 4 → 12.
  - flush coincident with an input handshake → request dropped.
- Reset: rst_n low mid-CALC at an arbitrary time (not clock-aligned) → outputs go to reset values asynchronously. A post-reset DIV 9 / 3 → 3. Random signed/unsigned ops are compared against a reference model for XLEN = 32 and 64.
